sev_seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a bank of common-anode seven-segment digits sharing one sev_seg_decoder instance.
- Holds a packed multi-digit value and cycles a one-hot, active-low digit select.
- Presents the matching 4-bit nibble to the decoder, with a dead-time gap between digits to suppress ghosting.
- New values are accepted by valid/ready handshake and applied only at frame boundaries, so a frame never tears.

---
 rtl/sev_seg_pkg.sv | 18 +
 rtl/sev_seg_lzb.sv | 26 ++
 rtl/sev_seg_scan_ctrl.sv | 144 ++++++++++++++
 tb/tb_sev_seg_scan_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sev_seg_pkg.sv
// Purpose: shared constants and scan-state type for the seven-segment scan controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sev_seg_pkg;

    // Width of one displayed digit
    localparam int NIBBLE_W = 4;

    // Decoder input that turns every segment off
    localparam logic [NIBBLE_W-1:0] BLANK_CODE = 4'hF;

    // DEAD: all digits deselected (anti-ghosting gap); ON: current digit driven
    typedef enum logic [0:0] {
        DEAD = 1'b0,
        ON   = 1'b1
    } scan_state_t;

endpackage

// File: rtl/sev_seg_lzb.sv
// Purpose: per-digit leading-zero blank mask over a packed multi-digit value.
// Latency: combinational.
// Backpressure: none.
module sev_seg_lzb
    import sev_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic [NIBBLE_W*NUM_DIGITS-1:0] value,
    output logic [NUM_DIGITS-1:0]          blank
);

    logic zero_above;

    // Walk from the most significant digit down; a digit blanks while every
    // digit at or above it is zero. Digit 0 always shows so zero reads "0".
    always_comb begin
        zero_above = 1'b1;
        blank      = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above & (value[i*NIBBLE_W +: NIBBLE_W] == '0);
            blank[i]   = (i != 0) && zero_above;
        end
    end

endmodule

// File: rtl/sev_seg_scan_ctrl.sv
// Purpose: time-multiplexed scan of NUM_DIGITS common-anode digits through one shared decoder.
// Latency: new value shows at the first slot of the frame after it is accepted; dec_number is registered.
// Backpressure: single pending buffer; value_ready low from acceptance until the next frame boundary.
module sev_seg_scan_ctrl
    import sev_seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int SLOT_CYCLES = 50000,
    parameter int DEAD_CYCLES = 500
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NIBBLE_W*NUM_DIGITS-1:0] value_in,
    input  logic                           value_valid,
    output logic                           value_ready,
    input  logic                           lzb_en,
    output logic [NIBBLE_W-1:0]            dec_number,
    output logic [NUM_DIGITS-1:0]          digit_sel_n,
    output logic                           frame_start
);

    localparam int VAL_W = NIBBLE_W * NUM_DIGITS;
    localparam int CNT_W = $clog2(SLOT_CYCLES);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    // Scan position and state
    logic              running;
    logic [CNT_W-1:0]  slot_cnt;
    logic [IDX_W-1:0]  digit_idx;
    scan_state_t       state;

    // Value storage
    logic [VAL_W-1:0]  display_reg;
    logic [VAL_W-1:0]  pending_reg;
    logic              pending_full;

    // Derived controls
    logic              slot_last;
    logic              idx_last;
    logic              xfer;
    logic              load_dec;
    logic [IDX_W-1:0]  load_idx;
    logic [VAL_W-1:0]  display_nxt;
    logic [NUM_DIGITS-1:0] blank_mask;

    assign value_ready = ~pending_full;
    assign slot_last   = (slot_cnt == SLOT_LAST);
    assign idx_last    = (digit_idx == IDX_LAST);

    // Swap in the pending value on the very last cycle of the frame so the
    // next frame's first slot already decodes it and no frame ever tears.
    assign xfer        = running && slot_last && idx_last && pending_full;
    assign display_nxt = xfer ? pending_reg : display_reg;

    // dec_number reloads at the edge that starts each slot; the edge that
    // leaves the post-reset idle cycle starts slot 0 of the first frame.
    assign load_dec = !running || slot_last;
    assign load_idx = (!running || idx_last) ? '0 : digit_idx + 1'b1;

    assign frame_start = running && (slot_cnt == '0) && (digit_idx == '0);

    sev_seg_lzb #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_lzb (
        .value (display_nxt),
        .blank (blank_mask)
    );

    // Slot and digit counters; held at zero until the first edge after reset
    // so that cycle is slot 0 cycle 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running   <= 1'b0;
            slot_cnt  <= '0;
            digit_idx <= '0;
        end else if (!running) begin
            running <= 1'b1;
        end else begin
            slot_cnt <= slot_last ? '0 : slot_cnt + 1'b1;
            if (slot_last) begin
                digit_idx <= idx_last ? '0 : digit_idx + 1'b1;
            end
        end
    end

    // Dead-time / on-time phase within each slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= DEAD;
        end else if (running) begin
            case (state)
                DEAD:    if (slot_cnt == DEAD_LAST) state <= ON;
                ON:      if (slot_last)             state <= DEAD;
                default: state <= DEAD;
            endcase
        end
    end

    // Pending buffer fill on handshake, drain into the display at frame end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            display_reg  <= '0;
            pending_reg  <= '0;
            pending_full <= 1'b0;
        end else begin
            if (xfer) begin
                display_reg  <= pending_reg;
                pending_full <= 1'b0;
            end
            if (value_valid && value_ready) begin
                pending_reg  <= value_in;
                pending_full <= 1'b1;
            end
        end
    end

    // Registered nibble for the upcoming slot, blanked when it is a leading zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_number <= BLANK_CODE;
        end else if (load_dec) begin
            if (lzb_en && blank_mask[load_idx]) begin
                dec_number <= BLANK_CODE;
            end else begin
                dec_number <= display_nxt[load_idx*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    // Active-low one-hot digit enable, only during the ON phase
    always_comb begin
        digit_sel_n = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (state == ON && digit_idx == IDX_W'(i)) begin
                digit_sel_n[i] = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sev_seg_scan_ctrl.sv
module tb_sev_seg_scan_ctrl;

    localparam int ND = 4;
    localparam int SC = 8;
    localparam int DC = 2;
    localparam int FR = ND * SC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] value_in = '0;
    logic        value_valid = 1'b0;
    logic        value_ready;
    logic        lzb_en = 1'b0;
    logic [3:0]  dec_number;
    logic [3:0]  digit_sel_n;
    logic        frame_start;

    int checks = 0;
    int errors = 0;

    // Reference model: cycle position since scan start, shown value, pending buffer
    int          m_t    = -1;
    logic [15:0] m_disp = '0;
    logic [15:0] m_pend = '0;
    logic        m_full = 1'b0;
    logic [3:0]  m_dec  = 4'hF;

    sev_seg_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .SLOT_CYCLES (SC),
        .DEAD_CYCLES (DC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .value_in    (value_in),
        .value_valid (value_valid),
        .value_ready (value_ready),
        .lzb_en      (lzb_en),
        .dec_number  (dec_number),
        .digit_sel_n (digit_sel_n),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1);
    end

    // Digit s of v as the display should render it
    function automatic logic [3:0] ref_digit(logic [15:0] v, int s, logic l);
        logic [15:0] upper;
        upper = v >> (4 * s);
        if (l && s > 0 && upper == 16'h0) return 4'hF;
        return upper[3:0];
    endfunction

    function automatic logic [3:0] exp_sel();
        logic [3:0] one;
        if (m_t < 0) return 4'hF;
        if ((m_t % SC) < DC) return 4'hF;
        one = 4'b0001;
        return ~(one << ((m_t / SC) % ND));
    endfunction

    function automatic logic exp_fs();
        return (m_t >= 0) && (m_t % FR == 0);
    endfunction

    function automatic logic [3:0] const_nibble(logic [15:0] pk);
        logic [15:0] sh;
        sh = pk >> (4 * ((m_t / SC) % ND));
        return sh[3:0];
    endfunction

    // One clock edge; model advances using the inputs present at that edge
    task automatic step();
        logic        v;
        logic [15:0] d;
        logic        l;
        logic        acc;
        logic        fe;
        v = value_valid;
        d = value_in;
        l = lzb_en;
        @(posedge clk);
        #1;
        acc = v && !m_full;
        fe  = (m_t >= 0) && (m_t % FR == FR - 1);
        if (fe && m_full) begin
            m_disp = m_pend;
            m_full = 1'b0;
        end
        if (acc) begin
            m_pend = d;
            m_full = 1'b1;
        end
        m_t++;
        if (m_t % SC == 0) m_dec = ref_digit(m_disp, (m_t / SC) % ND, l);
    endtask

    task automatic model_reset();
        m_t = -1; m_disp = '0; m_pend = '0; m_full = 1'b0; m_dec = 4'hF;
    endtask

    task automatic advance_to(int pos);
        int n;
        n = 0;
        while ((m_t % FR) != pos && n < 100) begin
            step();
            n++;
        end
        checks++;
        if ((m_t % FR) != pos) begin
            errors++;
            $display("FAIL advance_to: frame position %0d, required %0d", m_t % FR, pos);
        end
    endtask

    task automatic offer(logic [15:0] v);
        int n;
        n = 0;
        while (!value_ready && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (value_ready !== 1'b1) begin
            errors++;
            $display("FAIL offer_ready: value_ready %b, required 1", value_ready);
        end
        value_in    = v;
        value_valid = 1'b1;
        step();
        value_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks += 4;
        if (dec_number !== 4'hF) begin errors++; $display("FAIL rst_dec: got %h required F", dec_number); end
        if (digit_sel_n !== 4'hF) begin errors++; $display("FAIL rst_sel: got %b required 1111", digit_sel_n); end
        if (value_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b required 1", value_ready); end
        if (frame_start !== 1'b0) begin errors++; $display("FAIL rst_fs: got %b required 0", frame_start); end
        model_reset();
        rst_n = 1'b1;
        #2;
        checks += 2;
        if (frame_start !== 1'b0) begin errors++; $display("FAIL rel_fs: got %b required 0", frame_start); end
        if (dec_number !== 4'hF) begin errors++; $display("FAIL rel_dec: got %h required F", dec_number); end
        step();
        checks += 3;
        if (frame_start !== 1'b1) begin errors++; $display("FAIL c0_fs: got %b required 1", frame_start); end
        if (digit_sel_n !== 4'hF) begin errors++; $display("FAIL c0_sel: got %b required 1111", digit_sel_n); end
        if (dec_number !== 4'h0) begin errors++; $display("FAIL c0_dec: got %h required 0", dec_number); end
        for (int i = 1; i <= 3; i++) begin
            step();
            checks += 3;
            if (digit_sel_n !== ((i < DC) ? 4'hF : 4'hE)) begin errors++; $display("FAIL c%0d_sel: got %b", i, digit_sel_n); end
            if (dec_number !== 4'h0) begin errors++; $display("FAIL c%0d_dec: got %h required 0", i, dec_number); end
            if (frame_start !== 1'b0) begin errors++; $display("FAIL c%0d_fs: got %b required 0", i, frame_start); end
        end
    endtask

    task automatic test_load();
        value_in    = 16'h1234;
        value_valid = 1'b1;
        checks++;
        if (value_ready !== 1'b1) begin errors++; $display("FAIL load_rdy3: got %b required 1", value_ready); end
        step();
        value_valid = 1'b0;
        checks++;
        if (value_ready !== 1'b0) begin errors++; $display("FAIL load_rdy4: got %b required 0", value_ready); end
        while (m_t < FR - 1) begin
            step();
            checks += 2;
            if (dec_number !== 4'h0) begin errors++; $display("FAIL load_f0_dec t=%0d: got %h required 0", m_t, dec_number); end
            if (digit_sel_n !== exp_sel()) begin errors++; $display("FAIL load_f0_sel t=%0d: got %b required %b", m_t, digit_sel_n, exp_sel()); end
        end
        for (int i = 0; i < FR; i++) begin
            step();
            checks += 4;
            if (dec_number !== const_nibble(16'h1234)) begin errors++; $display("FAIL load_f1_dec t=%0d: got %h required %h", m_t, dec_number, const_nibble(16'h1234)); end
            if (digit_sel_n !== exp_sel()) begin errors++; $display("FAIL load_f1_sel t=%0d: got %b required %b", m_t, digit_sel_n, exp_sel()); end
            if (frame_start !== exp_fs()) begin errors++; $display("FAIL load_f1_fs t=%0d: got %b required %b", m_t, frame_start, exp_fs()); end
            if (value_ready !== 1'b1) begin errors++; $display("FAIL load_f1_rdy t=%0d: got %b required 1", m_t, value_ready); end
        end
    endtask

    task automatic test_lzb();
        logic [15:0] vals[8];
        logic        lz[8];
        logic [15:0] pk[3];
        vals[0] = 16'h0070; lz[0] = 1'b1; pk[0] = 16'hFF70;
        vals[1] = 16'h0000; lz[1] = 1'b1; pk[1] = 16'hFFF0;
        vals[2] = 16'h0000; lz[2] = 1'b0; pk[2] = 16'h0000;
        for (int k = 3; k < 8; k++) begin
            vals[k] = 16'($urandom) >> (4 * $urandom_range(0, 3));
            lz[k]   = 1'($urandom_range(0, 1));
        end
        for (int k = 0; k < 8; k++) begin
            lzb_en = lz[k];
            advance_to(4);
            offer(vals[k]);
            advance_to(0);
            for (int i = 0; i < FR; i++) begin
                checks += 3;
                if (dec_number !== m_dec) begin errors++; $display("FAIL lzb_dec v=%h t=%0d: got %h required %h", vals[k], m_t, dec_number, m_dec); end
                if (digit_sel_n !== exp_sel()) begin errors++; $display("FAIL lzb_sel t=%0d: got %b required %b", m_t, digit_sel_n, exp_sel()); end
                if (value_ready !== !m_full) begin errors++; $display("FAIL lzb_rdy t=%0d: got %b required %b", m_t, value_ready, !m_full); end
                if (k < 3 && (m_t % SC) == SC - 1) begin
                    checks++;
                    if (dec_number !== const_nibble(pk[k])) begin errors++; $display("FAIL lzb_const v=%h t=%0d: got %h required %h", vals[k], m_t, dec_number, const_nibble(pk[k])); end
                end
                step();
            end
        end
    endtask

    task automatic test_back_to_back();
        lzb_en = 1'b0;
        advance_to(4);
        offer(16'hAAAA);
        value_in    = 16'h5555;
        value_valid = 1'b1;
        step();
        checks++;
        if (value_ready !== 1'b0) begin errors++; $display("FAIL bp_held: got %b required 0", value_ready); end
        advance_to(0);
        checks++;
        if (value_ready !== 1'b1) begin errors++; $display("FAIL bp_rise: got %b required 1", value_ready); end
        step();
        value_valid = 1'b0;
        checks++;
        if (value_ready !== 1'b0) begin errors++; $display("FAIL bp_accept: got %b required 0", value_ready); end
        for (int i = 1; i < FR; i++) begin
            checks += 3;
            if (dec_number !== 4'hA) begin errors++; $display("FAIL bp_a_dec t=%0d: got %h required A", m_t, dec_number); end
            if (dec_number !== m_dec) begin errors++; $display("FAIL bp_a_model t=%0d: got %h required %h", m_t, dec_number, m_dec); end
            if (digit_sel_n !== exp_sel()) begin errors++; $display("FAIL bp_a_sel t=%0d: got %b required %b", m_t, digit_sel_n, exp_sel()); end
            step();
        end
        for (int i = 0; i < FR; i++) begin
            checks += 2;
            if (dec_number !== 4'h5) begin errors++; $display("FAIL bp_5_dec t=%0d: got %h required 5", m_t, dec_number); end
            if (frame_start !== exp_fs()) begin errors++; $display("FAIL bp_5_fs t=%0d: got %b required %b", m_t, frame_start, exp_fs()); end
            step();
        end
    endtask

    task automatic test_coincident();
        advance_to(FR - 1);
        value_in    = 16'h9999;
        value_valid = 1'b1;
        checks++;
        if (value_ready !== 1'b1) begin errors++; $display("FAIL co_rdy_pre: got %b required 1", value_ready); end
        step();
        value_valid = 1'b0;
        checks++;
        if (value_ready !== 1'b0) begin errors++; $display("FAIL co_rdy_post: got %b required 0", value_ready); end
        for (int i = 0; i < FR; i++) begin
            checks += 2;
            if (dec_number !== 4'h5) begin errors++; $display("FAIL co_old_dec t=%0d: got %h required 5", m_t, dec_number); end
            if (dec_number !== m_dec) begin errors++; $display("FAIL co_old_model t=%0d: got %h required %h", m_t, dec_number, m_dec); end
            step();
        end
        for (int i = 0; i < FR; i++) begin
            checks += 2;
            if (dec_number !== 4'h9) begin errors++; $display("FAIL co_new_dec t=%0d: got %h required 9", m_t, dec_number); end
            if (digit_sel_n !== exp_sel()) begin errors++; $display("FAIL co_new_sel t=%0d: got %b required %b", m_t, digit_sel_n, exp_sel()); end
            step();
        end
    endtask

    task automatic test_reset_mid();
        advance_to(2 * SC + 3);
        #2;
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (dec_number !== 4'hF) begin errors++; $display("FAIL mid_dec: got %h required F", dec_number); end
        if (digit_sel_n !== 4'hF) begin errors++; $display("FAIL mid_sel: got %b required 1111", digit_sel_n); end
        if (value_ready !== 1'b1) begin errors++; $display("FAIL mid_rdy: got %b required 1", value_ready); end
        if (frame_start !== 1'b0) begin errors++; $display("FAIL mid_fs: got %b required 0", frame_start); end
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < FR; i++) begin
            checks += 3;
            if (dec_number !== 4'h0) begin errors++; $display("FAIL mid_post_dec t=%0d: got %h required 0", m_t, dec_number); end
            if (digit_sel_n !== exp_sel()) begin errors++; $display("FAIL mid_post_sel t=%0d: got %b required %b", m_t, digit_sel_n, exp_sel()); end
            if (frame_start !== exp_fs()) begin errors++; $display("FAIL mid_post_fs t=%0d: got %b required %b", m_t, frame_start, exp_fs()); end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_lzb();
        test_back_to_back();
        test_coincident();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
